// File: rtl/msg_proto_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : msg_proto_pkg
//  Desc     : Shared constants and state encoding for the 16-bit word message
//             protocol (tx framer and rx parser).
//  Revision : 1.0  initial release
// ============================================================================
package msg_proto_pkg;

    localparam logic [15:0] C_PREFIX          = 16'h55AA;
    localparam int          C_CMD_HAS_LEN_BIT = 0;
    localparam int          C_CMD_HAS_CHK_BIT = 1;
    localparam logic [15:0] C_CMD_EXIT        = 16'hFF00;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PREFIX = 3'd1,
        ST_CMD    = 3'd2,
        ST_LEN    = 3'd3,
        ST_DATA   = 3'd4,
        ST_CHK    = 3'd5
    } msg_state_t;

endpackage
`default_nettype wire

// File: rtl/msg_chksum_acc.sv
`default_nettype none
// ============================================================================
//  Module   : msg_chksum_acc
//  Desc     : 16-bit wrapping sum with synchronous clear and add-enable.
//  Revision : 1.0  initial release
// ============================================================================
module msg_chksum_acc (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clr,
    input  logic        i_add,
    input  logic [15:0] i_val,
    output logic [15:0] o_sum
);

    logic [15:0] r_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum <= '0;
        end else if (i_clr) begin
            r_sum <= '0;
        end else if (i_add) begin
            r_sum <= r_sum + i_val;
        end
    end

    assign o_sum = r_sum;

endmodule
`default_nettype wire

// File: rtl/msg_framer_tx.sv
`default_nettype none
// ============================================================================
//  Module   : msg_framer_tx
//  Desc     : Transmit framer: prefix, cod_cmd, optional len, payload, optional
//             checksum (checksum only when MSG_FRAMER_CHKSUM_EN is defined).
//  Revision : 1.0  initial release
// ============================================================================
module msg_framer_tx
    import msg_proto_pkg::*;
#(
    parameter logic [15:0] PREFIX = C_PREFIX,
    parameter int          LEN_W  = 8
) (
    input  logic             TX_CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [15:0]      CMD_IN,
    input  logic [LEN_W-1:0] LEN_IN,
    input  logic [15:0]      FIFO_Q,
    input  logic             FIFO_EMPTY,
    output logic             RD_REQ,
    input  logic             TX_RDY,
    output logic [15:0]      P_DATA_OUT,
    output logic             P_ENA_OUT,
    output logic             BUSY,
    output logic             DONE,
    output logic [7:0]       MSG_CNT
);

    msg_state_t       r_state;
    msg_state_t       w_state_nxt;
    logic [15:0]      r_cmd;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_cnt;
    logic [15:0]      r_data;
    logic             r_ena;
    logic             r_busy;
    logic             r_done;
    logic [7:0]       r_msg_cnt;

    logic             w_emit;
    logic             w_last;
    logic             w_accept;
    logic [15:0]      w_word;
    logic [15:0]      w_cmd_lat;
    logic [15:0]      w_chk_word;
    logic             w_has_len;
    logic             w_has_chk;
    logic             w_has_data;
    logic             w_data_last;

`ifdef MSG_FRAMER_CHKSUM_EN
    assign w_cmd_lat = CMD_IN;
    assign w_has_chk = r_cmd[C_CMD_HAS_CHK_BIT];

    msg_chksum_acc u_chksum (
        .clk   (TX_CLK),
        .rst_n (RST),
        .i_clr (w_accept),
        .i_add (w_emit && (r_state == ST_CMD || r_state == ST_LEN || r_state == ST_DATA)),
        .i_val (w_word),
        .o_sum (w_chk_word)
    );
`else
    // Without a checksum the receiver must never be told to expect one.
    assign w_cmd_lat  = CMD_IN & ~(16'd1 << C_CMD_HAS_CHK_BIT);
    assign w_has_chk  = 1'b0;
    assign w_chk_word = 16'h0000;
`endif

    assign w_accept    = (r_state == ST_IDLE) && START;
    assign w_has_len   = r_cmd[C_CMD_HAS_LEN_BIT];
    assign w_has_data  = (r_len != '0);
    assign w_data_last = (r_cnt == r_len - LEN_W'(1));
    assign RD_REQ      = (r_state == ST_DATA) && TX_RDY && !FIFO_EMPTY;

    always_ff @(posedge TX_CLK or negedge RST) begin
        if (!RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_word      = '0;
        w_emit      = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (START) w_state_nxt = ST_PREFIX;
            end
            ST_PREFIX: begin
                w_emit = TX_RDY;
                w_word = PREFIX;
                if (w_emit) w_state_nxt = ST_CMD;
            end
            ST_CMD: begin
                w_emit = TX_RDY;
                w_word = r_cmd;
                if (w_emit) begin
                    if (w_has_len)       w_state_nxt = ST_LEN;
                    else if (w_has_data) w_state_nxt = ST_DATA;
                    else if (w_has_chk)  w_state_nxt = ST_CHK;
                    else                 w_last      = 1'b1;
                end
            end
            ST_LEN: begin
                w_emit = TX_RDY;
                w_word = 16'(r_len);
                if (w_emit) begin
                    if (w_has_data)      w_state_nxt = ST_DATA;
                    else if (w_has_chk)  w_state_nxt = ST_CHK;
                    else                 w_last      = 1'b1;
                end
            end
            ST_DATA: begin
                w_emit = TX_RDY && !FIFO_EMPTY;
                w_word = FIFO_Q;
                if (w_emit && w_data_last) begin
                    if (w_has_chk) w_state_nxt = ST_CHK;
                    else           w_last      = 1'b1;
                end
            end
            ST_CHK: begin
                w_emit = TX_RDY;
                w_word = w_chk_word;
                if (w_emit) w_last = 1'b1;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_last) w_state_nxt = ST_IDLE;
    end

    always_ff @(posedge TX_CLK or negedge RST) begin
        if (!RST) begin
            r_cmd     <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_data    <= '0;
            r_ena     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_msg_cnt <= '0;
        end else begin
            r_ena  <= w_emit;
            r_done <= w_last;
            if (w_emit) r_data <= w_word;
            if (w_accept) begin
                r_cmd  <= w_cmd_lat;
                r_len  <= LEN_IN;
                r_cnt  <= '0;
                r_busy <= 1'b1;
            end
            if (r_state == ST_DATA && w_emit) r_cnt <= r_cnt + LEN_W'(1);
            if (w_last) begin
                r_busy    <= 1'b0;
                r_msg_cnt <= r_msg_cnt + 8'd1;
            end
        end
    end

    assign P_DATA_OUT = r_data;
    assign P_ENA_OUT  = r_ena;
    assign BUSY       = r_busy;
    assign DONE       = r_done;
    assign MSG_CNT    = r_msg_cnt;

endmodule
`default_nettype wire
